// File: rtl/tlu_trigger_buffer_pkg.sv
// tlu_trigger_buffer_pkg: shared types for the trigger-word elastic buffer
package tlu_trigger_buffer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } preempt_state_t;

endpackage

// File: rtl/tlu_trigger_buffer_mem.sv
// tlu_trigger_buffer_mem: DEPTHx32 register array, one write port, one async read port
// Ports: BUS_CLK clock; we/waddr/wdata write port; raddr/rdata combinational read port.
module tlu_trigger_buffer_mem #(
    parameter int DEPTH = 16
) (
    input  logic                     BUS_CLK,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [31:0]              wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge BUS_CLK)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];

endmodule

// File: rtl/tlu_trigger_buffer.sv
// tlu_trigger_buffer: FWFT elastic buffer for TLU trigger words with backpressure and preempt request
// Ports: BUS_CLK/BUS_RST_N clock and async active-low reset; IN_FIFO_* upstream FWFT port
// (IN_FIFO_READ pops it); OUT_FIFO_* downstream FWFT port; IN_NEAR_FULL backpressure;
// WORD_COUNT occupancy; LOST_COUNT saturating count of reads issued while empty.
module tlu_trigger_buffer
    import tlu_trigger_buffer_pkg::*;
#(
    parameter int DEPTH           = 16,
    parameter int NEAR_FULL_LEVEL = 12,
    parameter int PREEMPT_LEVEL   = 8
) (
    input  logic                   BUS_CLK,
    input  logic                   BUS_RST_N,
    input  logic                   IN_FIFO_EMPTY,
    input  logic [31:0]            IN_FIFO_DATA,
    input  logic                   IN_FIFO_PREEMPT_REQ,
    output logic                   IN_FIFO_READ,
    output logic                   IN_NEAR_FULL,
    input  logic                   OUT_FIFO_READ,
    output logic                   OUT_FIFO_EMPTY,
    output logic [31:0]            OUT_FIFO_DATA,
    output logic                   OUT_FIFO_PREEMPT_REQ,
    output logic [$clog2(DEPTH):0] WORD_COUNT,
    output logic [15:0]            LOST_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           en, push, pop;
    preempt_state_t state, state_nxt;

    // en holds pushes off for the first cycle after reset release and drops them asynchronously on reset
    assign push                 = en && !IN_FIFO_EMPTY && count < CW'(DEPTH);
    assign pop                  = OUT_FIFO_READ && count != '0;
    assign IN_FIFO_READ         = push;
    assign OUT_FIFO_EMPTY       = count == '0;
    assign WORD_COUNT           = count;
    assign OUT_FIFO_PREEMPT_REQ = state == ARMED;

    tlu_trigger_buffer_mem #(.DEPTH(DEPTH)) u_mem (
        .BUS_CLK(BUS_CLK),
        .we     (push),
        .waddr  (wr_ptr),
        .wdata  (IN_FIFO_DATA),
        .raddr  (rd_ptr),
        .rdata  (OUT_FIFO_DATA)
    );

    always_ff @(posedge BUS_CLK or negedge BUS_RST_N)
        if (!BUS_RST_N) begin
            en           <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            IN_NEAR_FULL <= 1'b0;
            LOST_COUNT   <= '0;
            state        <= IDLE;
        end else begin
            en           <= 1'b1;
            wr_ptr       <= wr_ptr + AW'(push);
            rd_ptr       <= rd_ptr + AW'(pop);
            count        <= count + CW'(push) - CW'(pop);
            IN_NEAR_FULL <= count >= CW'(NEAR_FULL_LEVEL);
            if (OUT_FIFO_READ && OUT_FIFO_EMPTY && LOST_COUNT != 16'hFFFF)
                LOST_COUNT <= LOST_COUNT + 16'd1;
            state        <= state_nxt;
        end

    // hysteresis: arm on level or upstream request, release only once fully drained
    always_comb begin
        state_nxt = state;
        state_nxt = (state == IDLE)
            ? ((count >= CW'(PREEMPT_LEVEL) || IN_FIFO_PREEMPT_REQ) ? ARMED : IDLE)
            : ((count == '0 && !IN_FIFO_PREEMPT_REQ) ? IDLE : ARMED);
    end

endmodule

// File: tb/tb_tlu_trigger_buffer.sv
// tb_tlu_trigger_buffer: queue-model checked bench for tlu_trigger_buffer
module tb_tlu_trigger_buffer;

    localparam int DEPTH = 16;
    localparam int NFL   = 12;
    localparam int PL    = 8;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_N = 1'b1;
    logic        IN_FIFO_EMPTY = 1'b1;
    logic [31:0] IN_FIFO_DATA = 32'h0;
    logic        IN_FIFO_PREEMPT_REQ = 1'b0;
    logic        IN_FIFO_READ;
    logic        IN_NEAR_FULL;
    logic        OUT_FIFO_READ = 1'b0;
    logic        OUT_FIFO_EMPTY;
    logic [31:0] OUT_FIFO_DATA;
    logic        OUT_FIFO_PREEMPT_REQ;
    logic [4:0]  WORD_COUNT;
    logic [15:0] LOST_COUNT;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] src[$];
    logic [31:0] q[$];
    int          m_lost;
    bit          m_nf, m_pre, m_en;

    tlu_trigger_buffer #(.DEPTH(DEPTH), .NEAR_FULL_LEVEL(NFL), .PREEMPT_LEVEL(PL)) dut (
        .BUS_CLK             (BUS_CLK),
        .BUS_RST_N           (BUS_RST_N),
        .IN_FIFO_EMPTY       (IN_FIFO_EMPTY),
        .IN_FIFO_DATA        (IN_FIFO_DATA),
        .IN_FIFO_PREEMPT_REQ (IN_FIFO_PREEMPT_REQ),
        .IN_FIFO_READ        (IN_FIFO_READ),
        .IN_NEAR_FULL        (IN_NEAR_FULL),
        .OUT_FIFO_READ       (OUT_FIFO_READ),
        .OUT_FIFO_EMPTY      (OUT_FIFO_EMPTY),
        .OUT_FIFO_DATA       (OUT_FIFO_DATA),
        .OUT_FIFO_PREEMPT_REQ(OUT_FIFO_PREEMPT_REQ),
        .WORD_COUNT          (WORD_COUNT),
        .LOST_COUNT          (LOST_COUNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check();
        chk("in_fifo_read", 32'(IN_FIFO_READ), 32'(m_en && !IN_FIFO_EMPTY && q.size() < DEPTH));
        chk("out_fifo_empty", 32'(OUT_FIFO_EMPTY), 32'(q.size() == 0));
        chk("word_count", 32'(WORD_COUNT), 32'(q.size()));
        if (q.size() != 0) chk("out_fifo_data", OUT_FIFO_DATA, q[0]);
        chk("lost_count", 32'(LOST_COUNT), 32'(m_lost));
        chk("in_near_full", 32'(IN_NEAR_FULL), 32'(m_nf));
        chk("preempt_req", 32'(OUT_FIFO_PREEMPT_REQ), 32'(m_pre));
    endtask

    task automatic model_reset();
        q.delete();
        m_lost = 0;
        m_nf   = 1'b0;
        m_pre  = 1'b0;
        m_en   = 1'b0;
    endtask

    // one cycle: starts and ends at a falling edge
    task automatic step(input bit rd, input bit gap, input bit req);
        bit push, pop, n_nf, n_pre;
        int n_lost;
        OUT_FIFO_READ       = rd;
        IN_FIFO_PREEMPT_REQ = req;
        IN_FIFO_EMPTY       = gap || src.size() == 0;
        IN_FIFO_DATA        = src.size() != 0 ? src[0] : 32'h0;
        #1;
        check();
        push   = m_en && !IN_FIFO_EMPTY && q.size() < DEPTH;
        pop    = rd && q.size() > 0;
        n_lost = (rd && q.size() == 0 && m_lost < 65535) ? m_lost + 1 : m_lost;
        n_nf   = q.size() >= NFL;
        n_pre  = m_pre ? !(q.size() == 0 && !req) : (q.size() >= PL || req);
        @(posedge BUS_CLK);
        if (pop) void'(q.pop_front());
        if (push) q.push_back(src.pop_front());
        m_lost = n_lost;
        m_nf   = n_nf;
        m_pre  = n_pre;
        m_en   = 1'b1;
        @(negedge BUS_CLK);
    endtask

    initial begin
        model_reset();
        #1 BUS_RST_N = 1'b0;
        #1 check();
        repeat (2) @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;

        // three words in, read back in order
        for (int i = 1; i <= 3; i++) src.push_back(32'hA000_0000 + 32'(i));
        repeat (4) step(0, 0, 0);
        chk("p1_count", 32'(WORD_COUNT), 32'd3);
        chk("p1_head", OUT_FIFO_DATA, 32'hA000_0001);
        repeat (3) step(1, 1, 0);
        chk("p1_empty", 32'(OUT_FIFO_EMPTY), 32'd1);

        // fill to full from a continuous supply, then drain
        for (int i = 0; i < 20; i++) src.push_back(32'hB000_0000 + 32'(i));
        repeat (20) step(0, 0, 0);
        chk("p2_count", 32'(WORD_COUNT), 32'd16);
        chk("p2_near_full", 32'(IN_NEAR_FULL), 32'd1);
        chk("p2_read_at_full", 32'(IN_FIFO_READ), 32'd0);
        chk("p2_preempt", 32'(OUT_FIFO_PREEMPT_REQ), 32'd1);
        repeat (15) step(1, 1, 0);
        chk("p2_preempt_at_1", 32'(OUT_FIFO_PREEMPT_REQ), 32'd1);
        step(1, 1, 0);
        chk("p2_preempt_hold", 32'(OUT_FIFO_PREEMPT_REQ), 32'd1);
        step(0, 1, 0);
        chk("p2_preempt_drop", 32'(OUT_FIFO_PREEMPT_REQ), 32'd0);
        src.delete();

        // push and pop together at count 5 across pointer wraps
        for (int i = 0; i < 5; i++) src.push_back(32'hC000_0000 + 32'(i));
        repeat (5) step(0, 0, 0);
        for (int i = 0; i < 100; i++) begin
            src.push_back(32'hC000_0100 + 32'(i));
            step(1, 0, 0);
        end
        chk("p3_count", 32'(WORD_COUNT), 32'd5);
        chk("p3_head", OUT_FIFO_DATA, 32'hC000_0100 + 32'd95);
        repeat (5) step(1, 1, 0);

        // reads on empty, then saturation
        repeat (3) step(1, 1, 0);
        chk("p4_lost3", 32'(LOST_COUNT), 32'd3);
        repeat (65536) step(1, 1, 0);
        chk("p4_lost_sat", 32'(LOST_COUNT), 32'h0000_FFFF);

        // upstream request alone arms preempt at empty
        step(0, 1, 1);
        chk("p5_req_arm", 32'(OUT_FIFO_PREEMPT_REQ), 32'd1);
        step(0, 1, 0);
        chk("p5_req_release", 32'(OUT_FIFO_PREEMPT_REQ), 32'd0);

        // randomized traffic with alternating fill/drain bias
        for (int i = 0; i < 3000; i++) begin
            if (src.size() < 4) src.push_back($urandom);
            step(((i / 200) % 2 == 1) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
        end

        // reset mid-stream at count 7
        for (int i = 0; i < 40 && q.size() != 0; i++) step(1, 1, 0);
        src.delete();
        for (int i = 0; i < 10; i++) src.push_back(32'hD000_0000 + 32'(i));
        for (int i = 0; i < 20 && q.size() < 7; i++) step(0, 0, 0);
        chk("p6_count7", 32'(WORD_COUNT), 32'd7);
        #2 BUS_RST_N = 1'b0;
        model_reset();
        #1 check();
        chk("p6_rst_read", 32'(IN_FIFO_READ), 32'd0);
        chk("p6_rst_empty", 32'(OUT_FIFO_EMPTY), 32'd1);
        chk("p6_rst_count", 32'(WORD_COUNT), 32'd0);
        chk("p6_rst_lost", 32'(LOST_COUNT), 32'd0);
        chk("p6_rst_nf", 32'(IN_NEAR_FULL), 32'd0);
        chk("p6_rst_pre", 32'(OUT_FIFO_PREEMPT_REQ), 32'd0);
        @(negedge BUS_CLK);
        BUS_RST_N = 1'b1;
        repeat (2) step(0, 1, 0);
        chk("p6_post_empty", 32'(OUT_FIFO_EMPTY), 32'd1);
        chk("p6_post_count", 32'(WORD_COUNT), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
